// File: rtl/operand_forward.sv
// D/E and E/M operand forwarding datapath with stall watchdog.
// Optional OPERAND_FORWARD_PERF_EN adds stall/bubble cycle counters.
module operand_forward #(
   parameter int XLEN        = 32,
   parameter int STALL_LIMIT = 8,
   parameter int CNT_W       = 4
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            fetch_stall,
   input  logic            flush_e,
   input  logic            valid_d,
   input  logic [1:0]      rs1_bypass_d,
   input  logic [2:0]      rs2_bypass_d,
   input  logic [XLEN-1:0] rs1_data_d,
   input  logic [XLEN-1:0] rs2_data_d,
   input  logic [XLEN-1:0] alu_result_m,
   input  logic [XLEN-1:0] wb_data_w,
   output logic            pc_enable,
   output logic            fd_enable,
   output logic            valid_e,
   output logic [XLEN-1:0] rs1_val_e,
   output logic [XLEN-1:0] rs2_val_e,
   output logic            valid_m,
   output logic [XLEN-1:0] store_data_m,
   output logic            stall_timeout
`ifdef OPERAND_FORWARD_PERF_EN
  ,output logic [31:0]     stall_cycles,
   output logic [31:0]     bubble_cycles
`endif
);

   logic            bubble;
   logic            valid_e_q, valid_e_d;
   logic [1:0]      sel1_e_q, sel1_e_d;
   logic [2:0]      sel2_e_q, sel2_e_d;
   logic [XLEN-1:0] r1_e_q, r1_e_d;
   logic [XLEN-1:0] r2_e_q, r2_e_d;
   logic            valid_m_q;
   logic [2:0]      sel2_m_q;
   logic [XLEN-1:0] sd_m_q;
   logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
   logic            timeout_q, timeout_d;

   assign bubble    = fetch_stall | flush_e;
   assign pc_enable = ~fetch_stall;
   assign fd_enable = ~fetch_stall;

   always_comb begin
      valid_e_d = 1'b0;
      sel1_e_d  = '0;
      sel2_e_d  = '0;
      r1_e_d    = '0;
      r2_e_d    = '0;
      if (!bubble) begin
         valid_e_d = valid_d;
         r1_e_d    = rs1_data_d;
         r2_e_d    = rs2_data_d;
         // invalid slots never forward, so later stages see select 0
         if (valid_d) begin
            sel1_e_d = rs1_bypass_d;
            sel2_e_d = rs2_bypass_d;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_e_q <= 1'b0;
         sel1_e_q  <= '0;
         sel2_e_q  <= '0;
         r1_e_q    <= '0;
         r2_e_q    <= '0;
      end else begin
         valid_e_q <= valid_e_d;
         sel1_e_q  <= sel1_e_d;
         sel2_e_q  <= sel2_e_d;
         r1_e_q    <= r1_e_d;
         r2_e_q    <= r2_e_d;
      end
   end

   always_comb begin
      rs1_val_e = r1_e_q;
      unique case (sel1_e_q)
         2'd1:    rs1_val_e = alu_result_m;
         2'd3:    rs1_val_e = wb_data_w;
         default: rs1_val_e = r1_e_q;
      endcase
   end

   always_comb begin
      rs2_val_e = r2_e_q;
      unique case (sel2_e_q)
         3'd1:    rs2_val_e = alu_result_m;
         3'd3:    rs2_val_e = wb_data_w;
         default: rs2_val_e = r2_e_q;
      endcase
   end

   assign valid_e = valid_e_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_m_q <= 1'b0;
         sel2_m_q  <= '0;
         sd_m_q    <= '0;
      end else begin
         valid_m_q <= valid_e_q;
         sel2_m_q  <= sel2_e_q;
         sd_m_q    <= rs2_val_e;
      end
   end

   assign valid_m      = valid_m_q;
   assign store_data_m = (valid_m_q && sel2_m_q == 3'd4) ? wb_data_w
                                                         : sd_m_q;

   always_comb begin
      run_cnt_d = '0;
      timeout_d = timeout_q;
      if (fetch_stall) begin
         run_cnt_d = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + 1'b1;
         if (run_cnt_q == CNT_W'(STALL_LIMIT - 1))
            timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         run_cnt_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         run_cnt_q <= run_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign stall_timeout = timeout_q;

`ifdef OPERAND_FORWARD_PERF_EN
   logic [31:0] stall_cnt_q, bubble_cnt_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         if (fetch_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (bubble)      bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
   end

   assign stall_cycles  = stall_cnt_q;
   assign bubble_cycles = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_operand_forward.sv
// Testbench for operand_forward: directed scenarios plus randomized
// traffic checked against an instruction-level reference model.
module tb_operand_forward;

   localparam int XLEN = 32;
   localparam int LIMIT = 8;

   logic            clock = 1'b0;
   logic            reset_n;
   logic            fetch_stall, flush_e, valid_d;
   logic [1:0]      rs1_bypass_d;
   logic [2:0]      rs2_bypass_d;
   logic [XLEN-1:0] rs1_data_d, rs2_data_d, alu_result_m, wb_data_w;
   logic            pc_enable, fd_enable, valid_e, valid_m, stall_timeout;
   logic [XLEN-1:0] rs1_val_e, rs2_val_e, store_data_m;
`ifdef OPERAND_FORWARD_PERF_EN
   logic [31:0]     stall_cycles, bubble_cycles;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   operand_forward #(.XLEN(XLEN), .STALL_LIMIT(LIMIT), .CNT_W(4)) dut (
      .clock(clock), .reset_n(reset_n),
      .fetch_stall(fetch_stall), .flush_e(flush_e), .valid_d(valid_d),
      .rs1_bypass_d(rs1_bypass_d), .rs2_bypass_d(rs2_bypass_d),
      .rs1_data_d(rs1_data_d), .rs2_data_d(rs2_data_d),
      .alu_result_m(alu_result_m), .wb_data_w(wb_data_w),
      .pc_enable(pc_enable), .fd_enable(fd_enable),
      .valid_e(valid_e), .rs1_val_e(rs1_val_e), .rs2_val_e(rs2_val_e),
      .valid_m(valid_m), .store_data_m(store_data_m),
      .stall_timeout(stall_timeout)
`ifdef OPERAND_FORWARD_PERF_EN
     ,.stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles)
`endif
   );

   always #5 clock = ~clock;

   // Reference model: the instruction sitting in E and in M.
   typedef struct {
      bit              valid;
      int              sel1;
      int              sel2;
      logic [XLEN-1:0] d1;
      logic [XLEN-1:0] d2;
   } ins_t;

   ins_t            m_e;
   bit              m_mvalid;
   int              m_msel2;
   logic [XLEN-1:0] m_msd;
   int              m_consec;
   bit              m_timeout;
   longint          m_stalls, m_bubbles;

   function automatic logic [XLEN-1:0] pick(int sel, logic [XLEN-1:0] own);
      if (sel == 1) return alu_result_m;
      if (sel == 3) return wb_data_w;
      return own;
   endfunction

   function automatic logic [XLEN-1:0] exp_rs1();
      return pick(m_e.sel1, m_e.d1);
   endfunction

   function automatic logic [XLEN-1:0] exp_rs2();
      return pick(m_e.sel2, m_e.d2);
   endfunction

   function automatic logic [XLEN-1:0] exp_sd();
      if (m_mvalid && m_msel2 == 4) return wb_data_w;
      return m_msd;
   endfunction

   function automatic void model_clear();
      m_e = '{valid: 0, sel1: 0, sel2: 0, d1: '0, d2: '0};
      m_mvalid = 0; m_msel2 = 0; m_msd = '0;
      m_consec = 0; m_timeout = 0;
      m_stalls = 0; m_bubbles = 0;
   endfunction

   task automatic idle_inputs();
      fetch_stall = 0; flush_e = 0; valid_d = 0;
      rs1_bypass_d = 0; rs2_bypass_d = 0;
      rs1_data_d = '0; rs2_data_d = '0;
      alu_result_m = '0; wb_data_w = '0;
   endtask

   // One clock: predict next state from the inputs now stable, then
   // advance to just after the edge.
   task automatic cycle();
      ins_t            ne;
      bit              nmv;
      int              nms;
      logic [XLEN-1:0] nsd;
      nmv = m_e.valid;
      nms = m_e.sel2;
      nsd = exp_rs2();
      if (fetch_stall || flush_e) begin
         ne = '{valid: 0, sel1: 0, sel2: 0, d1: '0, d2: '0};
         m_bubbles++;
      end else begin
         ne.valid = valid_d;
         ne.sel1  = valid_d ? int'(rs1_bypass_d) : 0;
         ne.sel2  = valid_d ? int'(rs2_bypass_d) : 0;
         ne.d1    = rs1_data_d;
         ne.d2    = rs2_data_d;
      end
      if (fetch_stall) begin
         m_consec++;
         m_stalls++;
         if (m_consec >= LIMIT) m_timeout = 1;
      end else begin
         m_consec = 0;
      end
      @(posedge clock);
      #1;
      m_e = ne;
      m_mvalid = nmv;
      m_msel2 = nms;
      m_msd = nsd;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n = 0;
      model_clear();
      #2;
      @(negedge clock);
      reset_n = 1;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      do_reset();
      tests_run++;
      if (valid_e !== 1'b0 || valid_m !== 1'b0 || stall_timeout !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_flags: ve=%b vm=%b to=%b want 0 0 0",
                  valid_e, valid_m, stall_timeout);
      end
      tests_run++;
      if (rs1_val_e !== '0 || rs2_val_e !== '0 || store_data_m !== '0) begin
         tests_failed++;
         $display("FAIL reset_data: %h %h %h want 0",
                  rs1_val_e, rs2_val_e, store_data_m);
      end
      tests_run++;
      if (pc_enable !== 1'b1 || fd_enable !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_enables: pc=%b fd=%b want 1 1",
                  pc_enable, fd_enable);
      end
   endtask

   task automatic test_no_hazard();
      idle_inputs();
      valid_d = 1; rs1_data_d = 32'h11; rs2_data_d = 32'h22;
      cycle();
      valid_d = 0;
      tests_run++;
      if (valid_e !== 1'b1 || rs1_val_e !== 32'h11 || rs2_val_e !== 32'h22) begin
         tests_failed++;
         $display("FAIL no_hazard_e: ve=%b r1=%h r2=%h want 1 11 22",
                  valid_e, rs1_val_e, rs2_val_e);
      end
      cycle();
      tests_run++;
      if (valid_m !== 1'b1 || store_data_m !== 32'h22) begin
         tests_failed++;
         $display("FAIL no_hazard_m: vm=%b sd=%h want 1 22",
                  valid_m, store_data_m);
      end
   endtask

   task automatic test_bypass();
      idle_inputs();
      valid_d = 1; rs1_bypass_d = 1; rs2_bypass_d = 3;
      rs1_data_d = 32'h1; rs2_data_d = 32'h2;
      cycle();
      valid_d = 0; rs1_bypass_d = 0; rs2_bypass_d = 0;
      alu_result_m = 32'hAAAA; wb_data_w = 32'h5555;
      #1;
      tests_run++;
      if (rs1_val_e !== 32'hAAAA || rs2_val_e !== 32'h5555) begin
         tests_failed++;
         $display("FAIL bypass_mw: r1=%h r2=%h want aaaa 5555",
                  rs1_val_e, rs2_val_e);
      end
      alu_result_m = 32'h1234; wb_data_w = 32'h4321;
      #1;
      tests_run++;
      if (rs1_val_e !== 32'h1234 || rs2_val_e !== 32'h4321) begin
         tests_failed++;
         $display("FAIL bypass_zero_lat: r1=%h r2=%h want 1234 4321",
                  rs1_val_e, rs2_val_e);
      end
      cycle();
   endtask

   task automatic test_store();
      logic [2:0] byp [2];
      logic [XLEN-1:0] want [2];
      byp[0] = 3'd4; want[0] = 32'hBEEF;
      byp[1] = 3'd0; want[1] = 32'hDEAD;
      for (int i = 0; i < 2; i++) begin
         idle_inputs();
         valid_d = 1; rs2_bypass_d = byp[i]; rs2_data_d = 32'hDEAD;
         cycle();
         idle_inputs();
         cycle();
         wb_data_w = 32'hBEEF;
         #1;
         tests_run++;
         if (store_data_m !== want[i]) begin
            tests_failed++;
            $display("FAIL store_sel%0d: got %h want %h",
                     byp[i], store_data_m, want[i]);
         end
      end
   endtask

   task automatic test_stall_flush();
      idle_inputs();
      valid_d = 1; rs1_data_d = 32'h77;
      fetch_stall = 1;
      #1;
      tests_run++;
      if (pc_enable !== 1'b0 || fd_enable !== 1'b0) begin
         tests_failed++;
         $display("FAIL stall_enables: pc=%b fd=%b want 0 0",
                  pc_enable, fd_enable);
      end
      cycle();
      tests_run++;
      if (valid_e !== 1'b0 || rs1_val_e !== '0) begin
         tests_failed++;
         $display("FAIL stall_bubble: ve=%b r1=%h want 0 0",
                  valid_e, rs1_val_e);
      end
      fetch_stall = 1; flush_e = 1;
      cycle();
      fetch_stall = 0; flush_e = 0;
      tests_run++;
      if (valid_e !== 1'b0) begin
         tests_failed++;
         $display("FAIL stall_flush: ve=%b want 0", valid_e);
      end
      cycle();
      tests_run++;
      if (valid_e !== 1'b1 || rs1_val_e !== 32'h77) begin
         tests_failed++;
         $display("FAIL after_flush: ve=%b r1=%h want 1 77",
                  valid_e, rs1_val_e);
      end
   endtask

   task automatic test_watchdog();
      idle_inputs();
      do_reset();
      fetch_stall = 1;
      repeat (7) cycle();
      fetch_stall = 0;
      cycle();
      tests_run++;
      if (stall_timeout !== 1'b0) begin
         tests_failed++;
         $display("FAIL wd_7: got %b want 0", stall_timeout);
      end
      fetch_stall = 1;
      repeat (7) cycle();
      tests_run++;
      if (stall_timeout !== 1'b0) begin
         tests_failed++;
         $display("FAIL wd_before_8: got %b want 0", stall_timeout);
      end
      cycle();
      tests_run++;
      if (stall_timeout !== 1'b1) begin
         tests_failed++;
         $display("FAIL wd_8: got %b want 1", stall_timeout);
      end
      fetch_stall = 0;
      repeat (3) cycle();
      tests_run++;
      if (stall_timeout !== 1'b1) begin
         tests_failed++;
         $display("FAIL wd_sticky: got %b want 1", stall_timeout);
      end
      do_reset();
      tests_run++;
      if (stall_timeout !== 1'b0) begin
         tests_failed++;
         $display("FAIL wd_reset: got %b want 0", stall_timeout);
      end
   endtask

   task automatic test_async_reset();
      idle_inputs();
      fetch_stall = 1;
      repeat (8) cycle();
      fetch_stall = 0;
      valid_d = 1; rs1_data_d = 32'h99; rs2_data_d = 32'h88;
      cycle();
      cycle();
      fetch_stall = 1;
      #2;
      tests_run++;
      if (valid_e !== 1'b1 || valid_m !== 1'b1 || stall_timeout !== 1'b1) begin
         tests_failed++;
         $display("FAIL arst_pre: ve=%b vm=%b to=%b want 1 1 1",
                  valid_e, valid_m, stall_timeout);
      end
      reset_n = 0;
      model_clear();
      #1;
      tests_run++;
      if (valid_e !== 1'b0 || valid_m !== 1'b0 || stall_timeout !== 1'b0 ||
          rs1_val_e !== '0 || rs2_val_e !== '0 || store_data_m !== '0) begin
         tests_failed++;
         $display("FAIL arst_clear: ve=%b vm=%b to=%b r1=%h r2=%h sd=%h want 0",
                  valid_e, valid_m, stall_timeout, rs1_val_e, rs2_val_e,
                  store_data_m);
      end
      tests_run++;
      if (pc_enable !== 1'b0) begin
         tests_failed++;
         $display("FAIL arst_pc_en: got %b want 0", pc_enable);
      end
      idle_inputs();
      @(negedge clock);
      reset_n = 1;
      @(posedge clock);
      #1;
   endtask

`ifdef OPERAND_FORWARD_PERF_EN
   task automatic test_perf();
      idle_inputs();
      do_reset();
      fetch_stall = 1;
      repeat (3) cycle();
      fetch_stall = 0; flush_e = 1;
      cycle();
      flush_e = 0;
      cycle();
      tests_run++;
      if (stall_cycles !== 32'd3 || bubble_cycles !== 32'd4) begin
         tests_failed++;
         $display("FAIL perf: stall=%0d bubble=%0d want 3 4",
                  stall_cycles, bubble_cycles);
      end
   endtask
`endif

   task automatic test_random();
      int bad = 0;
      idle_inputs();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         fetch_stall  = ($urandom_range(0, 9) < 3);
         flush_e      = ($urandom_range(0, 9) == 0);
         valid_d      = ($urandom_range(0, 9) < 8);
         rs1_bypass_d = 2'($urandom_range(0, 3));
         rs2_bypass_d = 3'($urandom_range(0, 7));
         rs1_data_d   = $urandom;
         rs2_data_d   = $urandom;
         alu_result_m = $urandom;
         wb_data_w    = $urandom;
         #1;
         tests_run++;
         if (valid_e !== m_e.valid || valid_m !== m_mvalid ||
             rs1_val_e !== exp_rs1() || rs2_val_e !== exp_rs2() ||
             store_data_m !== exp_sd() || stall_timeout !== m_timeout ||
             pc_enable !== !fetch_stall || fd_enable !== !fetch_stall) begin
            tests_failed++;
            bad++;
            if (bad < 10)
               $display("FAIL random[%0d]: ve=%b/%b vm=%b/%b r1=%h/%h r2=%h/%h sd=%h/%h to=%b/%b",
                        i, valid_e, m_e.valid, valid_m, m_mvalid,
                        rs1_val_e, exp_rs1(), rs2_val_e, exp_rs2(),
                        store_data_m, exp_sd(), stall_timeout, m_timeout);
         end
`ifdef OPERAND_FORWARD_PERF_EN
         tests_run++;
         if (stall_cycles !== 32'(m_stalls) || bubble_cycles !== 32'(m_bubbles)) begin
            tests_failed++;
            $display("FAIL random_perf[%0d]: stall=%0d/%0d bubble=%0d/%0d",
                     i, stall_cycles, m_stalls, bubble_cycles, m_bubbles);
         end
`endif
         cycle();
      end
   endtask

   initial begin
      reset_n = 1;
      idle_inputs();
      model_clear();
      test_reset();
      test_no_hazard();
      test_bypass();
      test_store();
      test_stall_flush();
      test_watchdog();
      test_async_reset();
`ifdef OPERAND_FORWARD_PERF_EN
      test_perf();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
